// File: rtl/exp3_fluxo_dados.sv
// Datapath of the memory-sequence checker: address counter, switch register,
// fixed ROM and the equality comparator that reports hit/miss to the controller.
module exp3_fluxo_dados #(
    parameter int unsigned N     = 4,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     zeraC,
    input  logic                     contaC,
    input  logic                     zeraR,
    input  logic                     registraR,
    input  logic [N-1:0]             chaves,
    output logic                     fimC,
    output logic                     igual,
    output logic [$clog2(DEPTH)-1:0] db_contagem,
    output logic [N-1:0]             db_memoria,
    output logic [N-1:0]             db_chaves
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

    logic [AW-1:0] count_q, count_d;
    logic [N-1:0]  chaves_q, chaves_d;
    logic [N-1:0]  rom_data;

    // Sequence table; addresses outside it read as zero.
    function automatic logic [3:0] rom_read(input logic [AW-1:0] addr);
        logic [3:0] word;
        case (32'(addr))
            0:       word = 4'b0001;
            1:       word = 4'b0010;
            2:       word = 4'b0100;
            3:       word = 4'b1000;
            4:       word = 4'b0100;
            5:       word = 4'b0010;
            6:       word = 4'b0001;
            7:       word = 4'b0001;
            8:       word = 4'b0010;
            9:       word = 4'b0010;
            10:      word = 4'b0100;
            11:      word = 4'b0100;
            12:      word = 4'b1000;
            13:      word = 4'b1000;
            14:      word = 4'b0001;
            15:      word = 4'b0100;
            default: word = 4'b0000;
        endcase
        return word;
    endfunction

    // Clear beats count; wrap at the last address is normal, end is judged via fimC.
    always_comb begin
        count_d = count_q;
        if (zeraC) begin
            count_d = '0;
        end else if (contaC) begin
            if (count_q == LastAddr) begin
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_comb begin
        chaves_d = chaves_q;
        if (zeraR) begin
            chaves_d = '0;
        end else if (registraR) begin
            chaves_d = chaves;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            chaves_q <= '0;
        end else begin
            count_q  <= count_d;
            chaves_q <= chaves_d;
        end
    end

    always_comb begin
        rom_data = N'(rom_read(count_q));
    end

    // Status is purely combinational from state so it is valid the cycle after a strobe.
    always_comb begin
        fimC        = (count_q == LastAddr);
        igual       = (chaves_q == rom_data);
        db_contagem = count_q;
        db_memoria  = rom_data;
        db_chaves   = chaves_q;
    end

endmodule
